// File: rtl/logic_op_if.sv
// Command/result bus for logic_op_unit: command handshake in, buffered result handshake out.
interface logic_op_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] r;
    logic       zf;
    logic       err;
    logic       pf;
    logic [7:0] cnt;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, r, zf, err, pf, cnt
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, r, zf, err, pf, cnt
    );
endinterface

// File: rtl/logic_op_unit.sv
// 4-bit bitwise logic unit feeding a DEPTH-entry result FIFO with flags.
// Optional macro LOGIC_OP_PARITY_EN stores an even-parity bit per entry on pf.
module logic_op_unit #(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    logic_op_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
`ifdef LOGIC_OP_PARITY_EN
    localparam int EW = 7;
`else
    localparam int EW = 6;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          started;
    logic [7:0]    cnt_q;
    logic [3:0]    res;
    logic          illegal;
    logic [EW-1:0] entry, head;
    logic          in_ready_i, out_valid_i, push, pop;

    always_comb begin
        res     = 4'd0;
        illegal = 1'b0;
        case (bus.op)
            3'b000:  res = bus.a & bus.b;
            3'b001:  res = bus.a | bus.b;
            3'b010:  res = bus.a ^ bus.b;
            3'b011:  res = ~(bus.a ^ bus.b);
            3'b100:  res = ~bus.a;
            default: illegal = 1'b1;
        endcase
    end

`ifdef LOGIC_OP_PARITY_EN
    assign entry = {res, (res == 4'd0), illegal, ^res};
`else
    assign entry = {res, (res == 4'd0), illegal};
`endif

    // in_ready comes from registered state only; started keeps it low until
    // the first edge after reset release.
    assign in_ready_i  = started && (occ < OW'(DEPTH));
    assign out_valid_i = (occ != '0);
    assign push        = bus.in_valid && in_ready_i;
    assign pop         = out_valid_i && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            occ     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            started <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cnt_q  <= cnt_q + 8'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is not reset; an empty buffer masks the head to zero instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head = out_valid_i ? mem[rd_ptr] : '0;

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.r         = head[EW-1 -: 4];
    assign bus.zf        = head[EW-5];
    assign bus.err       = head[EW-6];
    assign bus.cnt       = cnt_q;
`ifdef LOGIC_OP_PARITY_EN
    assign bus.pf        = head[0];
`else
    assign bus.pf        = 1'b0;
`endif
endmodule

// File: tb/tb_logic_op_unit.sv
// Directed self-checking bench for logic_op_unit at DEPTH=2.
module tb_logic_op_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sv;
    logic [5:0] m;

    logic_op_if ifc ();

    logic_op_unit #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pf(input logic [3:0] r);
`ifdef LOGIC_OP_PARITY_EN
        return ^r;
`else
        return 1'b0;
`endif
    endfunction

    // reference model: {r, zf, err}
    function automatic logic [5:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       e;
        e = 1'b0;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a ^ b);
            3'd4:    r = ~a;
            default: begin r = 4'd0; e = 1'b1; end
        endcase
        return {r, (r == 4'd0), e};
    endfunction

    task automatic drive(input logic iv, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic ordy);
        @(negedge clk);
        ifc.in_valid  = iv;
        ifc.op        = op;
        ifc.a         = a;
        ifc.b         = b;
        ifc.out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] r, input logic zf, input logic err);
        chk({tag, ".valid"}, 8'(ifc.out_valid), 8'd1);
        chk({tag, ".r"},     8'(ifc.r),   8'(r));
        chk({tag, ".zf"},    8'(ifc.zf),  8'(zf));
        chk({tag, ".err"},   8'(ifc.err), 8'(err));
        chk({tag, ".pf"},    8'(ifc.pf),  8'(exp_pf(r)));
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.op        = 3'd0;
        ifc.a         = 4'd0;
        ifc.b         = 4'd0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 8'(ifc.out_valid), 8'd0);
        chk("rst.in_ready",  8'(ifc.in_ready),  8'd0);
        chk("rst.r",         8'(ifc.r),         8'd0);
        chk("rst.zf",        8'(ifc.zf),        8'd0);
        chk("rst.err",       8'(ifc.err),       8'd0);
        chk("rst.pf",        8'(ifc.pf),        8'd0);
        chk("rst.cnt",       ifc.cnt,           8'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready_pre", 8'(ifc.in_ready), 8'd0);
        tick();
        chk("rel.in_ready_post", 8'(ifc.in_ready), 8'd1);

        // single AND command, consumed on the following edge
        drive(1'b1, 3'b000, 4'b1100, 4'b1010, 1'b1); tick();
        chk_res("and", 4'b1000, 1'b0, 1'b0);
        chk("and.cnt0", ifc.cnt, 8'd0);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("and.cnt1", ifc.cnt, 8'd1);
        chk("and.empty", 8'(ifc.out_valid), 8'd0);

        // remaining ops back-to-back with a=0110 b=0011
        drive(1'b1, 3'b001, 4'b0110, 4'b0011, 1'b1); tick(); chk_res("or",   4'b0111, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 4'b0110, 4'b0011, 1'b1); tick(); chk_res("xor",  4'b0101, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 4'b0110, 4'b0011, 1'b1); tick(); chk_res("xnor", 4'b1010, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 4'b0110, 4'b0011, 1'b1); tick(); chk_res("not",  4'b1001, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("ops.cnt", ifc.cnt, 8'd5);
        chk("ops.empty", 8'(ifc.out_valid), 8'd0);

        // illegal opcodes and an all-zero legal result
        drive(1'b1, 3'b110, 4'b1111, 4'b1111, 1'b1); tick(); chk_res("ill110", 4'b0000, 1'b1, 1'b1);
        drive(1'b1, 3'b101, 4'b0101, 4'b0011, 1'b1); tick(); chk_res("ill101", 4'b0000, 1'b1, 1'b1);
        drive(1'b1, 3'b000, 4'b0101, 4'b1010, 1'b1); tick(); chk_res("zero",   4'b0000, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("ill.cnt", ifc.cnt, 8'd8);

        // fill to FULL with out_ready low, then drain
        drive(1'b1, 3'b000, 4'b1111, 4'b0011, 1'b0); tick();
        chk("fill1.in_ready", 8'(ifc.in_ready), 8'd1);
        chk_res("fill1", 4'b0011, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 4'b0001, 4'b0100, 1'b0); tick();
        chk("fill2.in_ready", 8'(ifc.in_ready), 8'd0);
        chk_res("fill2", 4'b0011, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 4'b1111, 4'b0110, 1'b0); tick();
        chk("full.in_ready", 8'(ifc.in_ready), 8'd0);
        chk_res("full.hold", 4'b0011, 1'b0, 1'b0);
        chk("full.cnt", ifc.cnt, 8'd8);
        drive(1'b1, 3'b010, 4'b1111, 4'b0110, 1'b1); tick();
        chk("pop1.in_ready", 8'(ifc.in_ready), 8'd1);
        chk_res("pop1", 4'b0101, 1'b0, 1'b0);
        chk("pop1.cnt", ifc.cnt, 8'd9);
        drive(1'b1, 3'b010, 4'b1111, 4'b0110, 1'b0); tick();
        chk("acc3.in_ready", 8'(ifc.in_ready), 8'd0);
        chk_res("acc3", 4'b0101, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk_res("pop2", 4'b1001, 1'b0, 1'b0);
        chk("pop2.cnt", ifc.cnt, 8'd10);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("pop3.empty", 8'(ifc.out_valid), 8'd0);
        chk("pop3.cnt", ifc.cnt, 8'd11);

        // reset with two entries buffered
        drive(1'b1, 3'b000, 4'b1111, 4'b1111, 1'b0); tick();
        drive(1'b1, 3'b001, 4'b0000, 4'b0001, 1'b0); tick();
        chk("pre_rst.full", 8'(ifc.in_ready), 8'd0);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", 8'(ifc.out_valid), 8'd0);
        chk("mid_rst.cnt",       ifc.cnt,           8'd0);
        chk("mid_rst.in_ready",  8'(ifc.in_ready),  8'd0);
        chk("mid_rst.r",         8'(ifc.r),         8'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst.in_ready", 8'(ifc.in_ready), 8'd1);
        chk("post_rst.empty",    8'(ifc.out_valid), 8'd0);
        drive(1'b1, 3'b011, 4'b1100, 4'b1100, 1'b0); tick();
        chk_res("post_rst.head", 4'b1111, 1'b0, 1'b0);
        chk("post_rst.one_entry", 8'(ifc.in_ready), 8'd1);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("post_rst.cnt", ifc.cnt, 8'd1);
        chk("post_rst.drained", 8'(ifc.out_valid), 8'd0);

        // fresh reset, then 256 transfers with push and pop every edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2.cnt", ifc.cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            sv = 8'(i);
            drive(1'b1, sv[2:0], sv[3:0], sv[7:4] ^ 4'b1010, 1'b1);
            tick();
            m = model(sv[2:0], sv[3:0], sv[7:4] ^ 4'b1010);
            chk("stream.r",        8'(ifc.r),         8'(m[5:2]));
            chk("stream.zf",       8'(ifc.zf),        8'(m[1]));
            chk("stream.err",      8'(ifc.err),       8'(m[0]));
            chk("stream.in_ready", 8'(ifc.in_ready),  8'd1);
            chk("stream.valid",    8'(ifc.out_valid), 8'd1);
        end
        chk("stream.cnt255", ifc.cnt, 8'd255);
        drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b1); tick();
        chk("stream.cnt_wrap", ifc.cnt, 8'd0);
        chk("stream.empty", 8'(ifc.out_valid), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_op_unit.md
LOGIC_OP_UNIT -- requirements
Module: logic_op_unit

Interface
REQ-001 Parameter: DEPTH, 2, result-buffer entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  command valid.
REQ-005 in_ready  output  1  command accepted when in_valid && in_ready.
REQ-006 op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NOT a; 101-111 illegal.
REQ-007 a  input  4  operand A.
REQ-008 b  input  4  operand B; ignored for NOT.
REQ-009 out_valid  output  1  buffered result available.
REQ-010 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 r  output  4  result of head entry.
REQ-012 zf  output  1  head result == 4'b0000.
REQ-013 err  output  1  head entry came from an illegal opcode.
REQ-014 pf  output  1  parity flag (see Configuration).
REQ-015 cnt  output  8  count of completed output transfers.

Function
REQ-016 Each accepted command computes a 4-bit bitwise result per op, then writes {r, zf, err, pf} into a DEPTH-entry FIFO in the same clock edge.
REQ-017 An illegal op yields r = 0, zf = 1, err = 1.
REQ-018 Latency: accept on edge N, so out_valid = 1 after edge N when the FIFO was empty.
REQ-019 in_ready = 1 iff occupancy < DEPTH, decoded combinationally from registered occupancy only, with no path from out_ready.
REQ-020 out_valid = 1 iff occupancy > 0, and r/zf/err/pf always show the head entry.
REQ-021 Buffer states: EMPTY (occ = 0), PARTIAL (0 < occ < DEPTH), FULL (occ = DEPTH).
REQ-022 State transitions follow push/pop.
- Push-only: occupancy +1.
- Pop-only: occupancy -1.
- Push and pop on the same edge (legal only in PARTIAL): occupancy unchanged.
REQ-023 In FULL, in_ready = 0, and a pop frees one slot, so in_ready = 1 on the following cycle.
REQ-024 In EMPTY, out_ready is ignored and no pop occurs.
REQ-025 Write and read pointers wrap modulo DEPTH.
REQ-026 Entry order is strictly FIFO.
REQ-027 cnt increments on each output transfer and wraps 255 -> 0.
REQ-028 Outputs hold stable while out_valid && !out_ready.

Reset
REQ-029 rst_n low asynchronously clears occupancy, pointers and cnt.
- Output values under reset: out_valid = 0, in_ready = 0, r = 0, zf = 0, err = 0, pf = 0, cnt = 0.
REQ-030 in_ready rises on the first clk edge after rst_n deasserts.
REQ-031 Reset mid-operation discards all buffered entries, with no partial transfer.

Configuration
REQ-032 Macro LOGIC_OP_PARITY_EN, when defined, makes pf the even-parity bit of the result (XOR of r[3:0]), stored per entry.
REQ-033 Without LOGIC_OP_PARITY_EN, pf is tied to 0 and no parity storage is built.

Verification
REQ-034 Command op=000, a=1100, b=1010, with out_ready = 1: one cycle later r=1000, zf=0, err=0, pf=1 (macro on), and cnt goes 0 -> 1.
REQ-035 Each of op=001/010/011/100 with a=0110, b=0011: results 0111, 0101, 1010 and 1001 (the last from NOT a), in order.
REQ-036 Command op=110, a=1111, b=1111: r=0000, zf=1, err=1.
REQ-037 Fill and drain with out_ready = 0, sending 3 commands at DEPTH=2:
- in_ready drops after 2 accepts.
- Raising out_ready pops the first entry, and in_ready returns 1 the next cycle.
- The third command is then accepted and emerges last, in order.
REQ-038 Simultaneous push and pop in PARTIAL: occupancy stays 1 and results are in order; 256 transfers return cnt to 0.
REQ-039 Assert rst_n low while 2 entries are buffered: out_valid = 0 immediately and cnt = 0; after release, the first new command appears as the head.
